rgb_led_scheduler: RTL and testbench



---
 rtl/rgb_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/rgb_led_scheduler.sv | 179 +++++++++++++++++
 tb/tb_rgb_led_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and constants for the RGB LED scheduler.
//   state_t  : scheduler FSM state encoding (IDLE, SHOW, GAP)
//   BGR_*    : 3-bit LED colour codes, bit2=B, bit1=G, bit0=R
package rgb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [2:0] BGR_OFF = 3'b000;
  localparam logic [2:0] RED     = 3'b001;
  localparam logic [2:0] GREEN   = 3'b010;
  localparam logic [2:0] YELLOW  = 3'b011;
  localparam logic [2:0] BLUE    = 3'b100;
  localparam logic [2:0] MAGENTA = 3'b101;
  localparam logic [2:0] CYAN    = 3'b110;
  localparam logic [2:0] WHITE   = 3'b111;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     [NREQ-1:0] : request vector
//   pointer [PW-1:0]   : index of the last winner; search starts at pointer+1
//   winner  [NREQ-1:0] : one-hot winner, all zero when req is zero
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   pointer,
  output logic [NREQ-1:0] winner
);

  int unsigned idx;
  logic        found;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = (32'(pointer) + k) % NREQ;
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_led_scheduler.sv
// rgb_led_scheduler: shares one RGB LED between NREQ status requesters with
// round-robin fairness, a minimum dwell of DWELL ticks and a one-tick dark gap
// between owners. All outputs are registered.
//   clk, rst_n : clock, asynchronous active-low reset
//   tick       : single-cycle time-base enable
//   req        : per-requester level request
//   color_in   : BGR colour per requester, requester i at [3i+2:3i]
//   blink_in   : per-requester blink enable (only with RGB_BLINK_EN)
//   grant      : one-hot current owner, zero when none
//   busy       : high in SHOW and GAP
//   BGR        : LED drive, bit2=B, bit1=G, bit0=R
// Optional feature macro: RGB_BLINK_EN (blinking owner colour during SHOW).
module rgb_led_scheduler
  import rgb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DWELL = 3,
  parameter int CNTW  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [NREQ-1:0]   req,
  input  logic [3*NREQ-1:0] color_in,
`ifdef RGB_BLINK_EN
  input  logic [NREQ-1:0]   blink_in,
`endif
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic [2:0]        BGR
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t            state, state_nx;
  logic [CNTW-1:0]   cnt, cnt_nx;
  logic [PW-1:0]     ptr, ptr_nx;
  logic [NREQ-1:0]   grant_nx;
  logic              busy_nx;
  logic [2:0]        bgr_nx;

  logic [NREQ-1:0]   win;
  logic [PW-1:0]     win_idx;
  logic [2:0]        win_col, owner_col, cur_col, shown;
  logic              owner_req, others_req, load, stay_tick;

`ifdef RGB_BLINK_EN
  logic [2:0] col, col_nx;
  logic       blk, blk_nx, lit, lit_nx;
  assign cur_col = col;
`else
  assign cur_col = BGR;
`endif

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req    (req),
    .pointer(ptr),
    .winner (win)
  );

  always_comb begin
    win_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++)
      if (win[i]) win_idx = PW'(i);
  end

  // The pointer always holds the current owner's index while in SHOW.
  assign win_col    = color_in[3*int'(win_idx) +: 3];
  assign owner_col  = color_in[3*int'(ptr) +: 3];
  assign owner_req  = |(req & grant);
  assign others_req = |(req & ~grant);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    ptr_nx    = ptr;
    grant_nx  = grant;
    busy_nx   = busy;
    bgr_nx    = BGR;
    load      = 1'b0;
    stay_tick = 1'b0;
    shown     = cur_col;
`ifdef RGB_BLINK_EN
    col_nx = col;
    blk_nx = blk;
    lit_nx = lit;
`endif
    case (state)
      IDLE: load = |req;
      SHOW: begin
        // Owner dropping req wins over a same-cycle tick.
        if (!owner_req) begin
          state_nx = GAP;
          grant_nx = '0;
          bgr_nx   = BGR_OFF;
        end else if (tick) begin
          if (cnt == CNTW'(1)) begin
            if (others_req) begin
              state_nx = GAP;
              grant_nx = '0;
              bgr_nx   = BGR_OFF;
            end else begin
              cnt_nx    = CNTW'(DWELL);
              shown     = owner_col;
              stay_tick = 1'b1;
            end
          end else begin
            cnt_nx    = cnt - CNTW'(1);
            stay_tick = 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (|req) begin
            load = 1'b1;
          end else begin
            state_nx = IDLE;
            busy_nx  = 1'b0;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    if (load) begin
      state_nx = SHOW;
      grant_nx = win;
      ptr_nx   = win_idx;
      cnt_nx   = CNTW'(DWELL);
      busy_nx  = 1'b1;
      bgr_nx   = win_col;
`ifdef RGB_BLINK_EN
      col_nx = win_col;
      blk_nx = blink_in[win_idx];
      lit_nx = 1'b1;
`endif
    end

    if (stay_tick) begin
`ifdef RGB_BLINK_EN
      col_nx = shown;
      lit_nx = ~lit;
      bgr_nx = (blk && lit) ? BGR_OFF : shown;
`else
      bgr_nx = shown;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      ptr   <= PW'(NREQ - 1);
      grant <= '0;
      busy  <= 1'b0;
      BGR   <= BGR_OFF;
`ifdef RGB_BLINK_EN
      col   <= BGR_OFF;
      blk   <= 1'b0;
      lit   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      ptr   <= ptr_nx;
      grant <= grant_nx;
      busy  <= busy_nx;
      BGR   <= bgr_nx;
`ifdef RGB_BLINK_EN
      col   <= col_nx;
      blk   <= blk_nx;
      lit   <= lit_nx;
`endif
    end
  end

endmodule

// File: tb/tb_rgb_led_scheduler.sv
// Testbench for rgb_led_scheduler: directed scenarios plus randomized traffic,
// each cycle compared against an integer-level reference model.
module tb_rgb_led_scheduler;
  import rgb_pkg::*;

  localparam int NREQ  = 4;
  localparam int DWELL = 3;
  localparam int CNTW  = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick;
  logic [NREQ-1:0]   req;
  logic [3*NREQ-1:0] color_in;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic [2:0]        BGR;

  rgb_led_scheduler #(.NREQ(NREQ), .DWELL(DWELL), .CNTW(CNTW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .req     (req),
    .color_in(color_in),
`ifdef RGB_BLINK_EN
    .blink_in('0),
`endif
    .grant   (grant),
    .busy    (busy),
    .BGR     (BGR)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: owner index (-1 = none), ticks left, last winner, gap flag.
  int         m_owner, m_left, m_ptr;
  bit         m_gap;
  logic [2:0] m_col;

  function automatic int rr_pick(logic [NREQ-1:0] r, int p);
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  function void m_reset();
    m_owner = -1; m_left = 0; m_ptr = NREQ - 1; m_gap = 0; m_col = 3'b000;
  endfunction

  function void m_grab();
    int w;
    w = rr_pick(req, m_ptr);
    m_owner = w; m_ptr = w; m_left = DWELL; m_gap = 0;
    m_col = color_in[3*w +: 3];
  endfunction

  function void m_update();
    if (m_owner < 0 && !m_gap) begin
      if (req != 0) m_grab();
    end else if (m_gap) begin
      if (tick) begin
        if (req != 0) m_grab();
        else m_gap = 0;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1; m_gap = 1;
    end else if (tick) begin
      m_left--;
      if (m_left == 0) begin
        if ((req & ~(NREQ'(1) << m_owner)) == 0) begin
          m_left = DWELL;
          m_col  = color_in[3*m_owner +: 3];
        end else begin
          m_owner = -1; m_gap = 1;
        end
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    logic [NREQ-1:0] eg;
    eg = (m_owner >= 0) ? (NREQ'(1) << m_owner) : '0;
    check("model_grant", 32'(grant), 32'(eg));
    check("model_bgr",   32'(BGR),   32'((m_owner >= 0) ? m_col : 3'b000));
    check("model_busy",  32'(busy),  32'((m_owner >= 0) || m_gap));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) m_update(); else m_reset();
    #1 check_model();
  endtask

  task automatic tick_step();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; tick = 1'b0; color_in = '0;
    step();
    step();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    check("rst_bgr",   32'(BGR),   32'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [NREQ-1:0] seen[$];
    logic [NREQ-1:0] last;
    logic [NREQ-1:0] exp_order[5];

    m_reset();

    // Single held requester: reloads forever, never a gap.
    do_reset();
    color_in[2:0] = RED;
    req = 4'b0001;
    step();
    check("A_grant", 32'(grant), 32'h1);
    check("A_bgr",   32'(BGR),   32'(RED));
    for (int n = 0; n < 8; n++) begin
      repeat (2) step();
      tick_step();
      check("A_hold_grant", 32'(grant), 32'h1);
      check("A_hold_busy",  32'(busy),  32'h1);
    end

    // All requesting: round-robin order starting from requester 0.
    do_reset();
    color_in = {WHITE, BLUE, GREEN, RED};
    req = 4'b1111;
    last = '0;
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int c = 0; c < 300 && seen.size() < 5; c++) begin
      tick = (c % 3 == 1);
      step();
      if (grant != 0 && last == 0) seen.push_back(grant);
      last = grant;
    end
    tick = 1'b0;
    check("B_count", 32'(seen.size()), 32'd5);
    for (int k = 0; k < 5 && k < seen.size(); k++)
      check("B_order", 32'(seen[k]), 32'(exp_order[k]));

    // Owner drops req together with a tick: straight to GAP.
    do_reset();
    color_in[8:6] = BLUE;
    req = 4'b0100;
    step();
    check("C_grant", 32'(grant), 32'h4);
    tick_step();
    step();
    req = '0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("C_gap_grant", 32'(grant), 32'h0);
    check("C_gap_bgr",   32'(BGR),   32'h0);
    check("C_gap_busy",  32'(busy),  32'h1);
    tick_step();
    check("C_idle_busy", 32'(busy), 32'h0);

    // Colour change during SHOW is ignored until reload.
    do_reset();
    color_in[5:3] = GREEN;
    req = 4'b0010;
    step();
    color_in[5:3] = BLUE;
    step();
    step();
    check("D_hold_bgr", 32'(BGR), 32'(GREEN));
    tick_step();
    tick_step();
    check("D_hold2_bgr", 32'(BGR), 32'(GREEN));
    tick_step();
    check("D_reload_bgr",   32'(BGR),   32'(BLUE));
    check("D_reload_grant", 32'(grant), 32'h2);

    // Asynchronous reset in SHOW, then pointer restarts at NREQ-1.
    do_reset();
    color_in[2:0] = CYAN;
    req = 4'b0001;
    step();
    step();
    check("E_pre_grant", 32'(grant), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("E_async_grant", 32'(grant), 32'h0);
    check("E_async_bgr",   32'(BGR),   32'h0);
    check("E_async_busy",  32'(busy),  32'h0);
    m_reset();
    @(negedge clk);
    req = 4'b1000;
    color_in[11:9] = WHITE;
    rst_n = 1'b1;
    step();
    check("E_rel_grant", 32'(grant), 32'h8);
    check("E_rel_bgr",   32'(BGR),   32'(WHITE));

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) req = NREQ'($urandom);
      if ($urandom_range(0, 3) == 0) color_in = (3*NREQ)'($urandom);
      tick = ($urandom_range(0, 2) == 0);
      step();
    end
    tick = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
